// File: rtl/add_share_arb.sv
// add_share_arb: round-robin arbiter sharing one combinational 32-bit
// ripple-carry adder between two requesters. One operation is in flight
// at a time: latch operands, compute, register the result, then hold it
// until the consumer accepts it.
module add_share_arb #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic        ci0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic        ci1,
  output logic        ack1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_s,
  output logic        rsp_co,
  output logic        rsp_ovf,
  output logic        busy,
  output logic [15:0] done_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_CALC  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Shared adder: 32 chained full adders, carry-out in bit 32.
  function automatic logic [32:0] rca32(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci);
    logic [32:0] r;
    logic        c;
    r = 33'd0;
    c = ci;
    for (int i = 0; i < 32; i++) begin
      r[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    r[32] = c;
    return r;
  endfunction

  // Signed overflow: operands agree in sign but the sum does not.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_t      state_r, state_next_s;
  logic        ptr_r;
  logic [31:0] op_a_r, op_b_r;
  logic        op_ci_r, op_id_r;
  logic        ack0_r, ack1_r;
  logic        rsp_valid_r, rsp_id_r, rsp_co_r, rsp_ovf_r;
  logic [31:0] rsp_s_r;
  logic [15:0] done_cnt_r;
  logic        busy_r;
  logic        winner_s, grant_s, hs_s;
  logic [32:0] sum_s;

  assign grant_s = (state_r == ST_IDLE) && (req0 || req1);
  assign hs_s    = (state_r == ST_RESP) && rsp_valid_r && rsp_ready;
  assign sum_s   = rca32(op_a_r, op_b_r, op_ci_r);

  // Winner selection: a lone requester wins, otherwise the pointer decides.
  always_comb begin
    winner_s = ptr_r;
    if (req0 && !req1) begin
      winner_s = 1'b0;
    end else if (req1 && !req0) begin
      winner_s = 1'b1;
    end else begin
      winner_s = ptr_r;
    end
  end

  // Next-state logic for the operation sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req0 || req1) state_next_s = ST_GRANT;
        else              state_next_s = ST_IDLE;
      end
      ST_GRANT: state_next_s = ST_CALC;
      ST_CALC:  state_next_s = ST_RESP;
      ST_RESP: begin
        if (hs_s) state_next_s = ST_IDLE;
        else      state_next_s = ST_RESP;
      end
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State register; busy is registered from the next state so it tracks state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
    end
  end

  // Operand capture at the granting edge; only these values are ever used.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a_r  <= 32'd0;
      op_b_r  <= 32'd0;
      op_ci_r <= 1'b0;
      op_id_r <= 1'b0;
    end else if (grant_s) begin
      op_a_r  <= winner_s ? a1 : a0;
      op_b_r  <= winner_s ? b1 : b0;
      op_ci_r <= winner_s ? ci1 : ci0;
      op_id_r <= winner_s;
    end
  end

  // Acknowledge pulses: high only during the GRANT cycle for the winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
    end else begin
      ack0_r <= grant_s && !winner_s;
      ack1_r <= grant_s && winner_s;
    end
  end

  // Result registers: loaded at the end of GRANT, held until the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_s_r     <= 32'd0;
      rsp_co_r    <= 1'b0;
      rsp_ovf_r   <= 1'b0;
    end else if (state_r == ST_GRANT) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= op_id_r;
      rsp_s_r     <= sum_s[31:0];
      rsp_co_r    <= sum_s[32];
      rsp_ovf_r   <= ovf_calc(op_a_r[31], op_b_r[31], sum_s[31]);
    end else if (hs_s) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Completion counter and round-robin pointer advance on each accepted result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_cnt_r <= 16'd0;
      ptr_r      <= RR_INIT;
    end else if (hs_s) begin
      done_cnt_r <= done_cnt_r + 16'd1;
      ptr_r      <= ~rsp_id_r;
    end
  end

  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_s     = rsp_s_r;
  assign rsp_co    = rsp_co_r;
  assign rsp_ovf   = rsp_ovf_r;
  assign busy      = busy_r;
  assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: directed operations push hand-computed results
// into a scoreboard queue; a monitor pops one entry each time rsp_valid rises.
module tb_add_share_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, ci0 = 1'b0, req1 = 1'b0, ci1 = 1'b0;
  logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
  logic        ack0, ack1, rsp_valid, rsp_id, rsp_co, rsp_ovf, busy;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_s;
  logic [15:0] done_cnt;

  typedef struct packed {
    logic        id;
    logic [31:0] s;
    logic        co;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic mon_prev = 1'b0;
  int   checks = 0;
  int   errors = 0;

  add_share_arb #(.RR_INIT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .a0(a0), .b0(b0), .ci0(ci0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .ci1(ci1), .ack1(ack1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_s(rsp_s), .rsp_co(rsp_co), .rsp_ovf(rsp_ovf),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each new result presentation is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid && !mon_prev) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_id",  32'(rsp_id),  32'(mon_e.id));
        chk("rsp_s",   rsp_s,        mon_e.s);
        chk("rsp_co",  32'(rsp_co),  32'(mon_e.co));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(mon_e.ovf));
      end
    end
    mon_prev = rsp_valid;
  end

  task automatic push(input logic id, input logic [31:0] s, input logic co, input logic ovf);
    exp_t e;
    e.id = id; e.s = s; e.co = co; e.ovf = ovf;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for any ack; check it belongs to the expected requester.
  task automatic wait_ack(input logic id);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack0_val", 32'(ack0), 32'(!id));
    chk("ack1_val", 32'(ack1), 32'(id));
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(posedge clk); #1;
      if (!busy && !rsp_valid) idle = 1'b1;
    end
    chk("idle_reached", 32'(idle), 32'd1);
  endtask

  task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic [31:0] es, input logic eco,
                        input logic eovf);
    @(negedge clk);
    push(id, es, eco, eovf);
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; ci1 = ci; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; ci0 = ci; end
    wait_ack(id);
    if (id) req1 = 1'b0; else req0 = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_s", rsp_s, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(done_cnt), 32'd0);
    reset_n = 1'b1;

    // 1: basic op with cycle-exact timing
    @(negedge clk);
    push(1'b0, 32'd8, 1'b0, 1'b0);
    req0 = 1'b1; a0 = 32'h0000_0005; b0 = 32'd3; ci0 = 1'b0;
    @(posedge clk); #1;
    chk("t1_ack0", 32'(ack0), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid_early", 32'(rsp_valid), 32'd0);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("t1_ack0_pulse", 32'(ack0), 32'd0);
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    wait_idle();
    chk("t1_cnt", 32'(done_cnt), 32'd1);

    // 2: carry and overflow corners
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    chk("t2_cnt", 32'(done_cnt), 32'd4);

    // 3: both requesting after reset -> alternating 0,1,0,1
    do_reset();
    chk("t3_cnt_rst", 32'(done_cnt), 32'd0);
    @(negedge clk);
    req0 = 1'b1; a0 = 32'd10; b0 = 32'd20; ci0 = 1'b0;
    req1 = 1'b1; a1 = 32'h8000_0000; b1 = 32'h8000_0000; ci1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k[0]) push(1'b1, 32'h0000_0000, 1'b1, 1'b1);
      else      push(1'b0, 32'd30, 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      wait_ack(k[0]);
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      @(posedge clk); #1;
      chk("t3_ack_pulse", 32'({ack0, ack1}), 32'd0);
    end
    wait_idle();
    chk("t3_cnt", 32'(done_cnt), 32'd4);

    // 4: backpressure with requester 1 waiting
    @(negedge clk);
    rsp_ready = 1'b0;
    req0 = 1'b1; a0 = 32'h1234_5678; b0 = 32'h1111_1111; ci0 = 1'b0;
    req1 = 1'b1; a1 = 32'hFFFF_0000; b1 = 32'h0001_0000; ci1 = 1'b1;
    push(1'b0, 32'h2345_6789, 1'b0, 1'b0);
    push(1'b1, 32'h0000_0001, 1'b1, 1'b0);
    wait_ack(1'b0);
    req0 = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_s", rsp_s, 32'h2345_6789);
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_no_ack", 32'({ack0, ack1}), 32'd0);
    end
    rsp_ready = 1'b1;
    wait_ack(1'b1);
    req1 = 1'b0;
    wait_idle();
    chk("t4_cnt", 32'(done_cnt), 32'd6);

    // 5: asynchronous reset during CALC, then re-arbitration
    @(negedge clk);
    req0 = 1'b1; a0 = 32'h0000_00FF; b0 = 32'd1; ci0 = 1'b0;
    push(1'b0, 32'h0000_0100, 1'b0, 1'b0);
    wait_ack(1'b0);
    @(posedge clk); #1;
    chk("t5_calc_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_s", rsp_s, 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_cnt", 32'(done_cnt), 32'd0);
    chk("t5_rst_ack", 32'({ack0, ack1}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    push(1'b0, 32'h0000_0100, 1'b0, 1'b0);
    wait_ack(1'b0);
    req0 = 1'b0;
    wait_idle();
    chk("t5_cnt", 32'(done_cnt), 32'd1);

    // 6: counter wrap and carry-in from requester 1
    @(negedge clk);
    force dut.done_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.done_cnt_r;
    chk("t6_preload", 32'(done_cnt), 32'h0000_FFFF);
    run_op(1'b1, 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0);
    chk("t6_wrap", 32'(done_cnt), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
